// File: rtl/ifq_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : ifq_prefetch_unit
// Description : Instruction prefetch queue with PC generation feeding the
//               IF/ID register; one outstanding sequential fetch, small FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module ifq_prefetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_rdata,
    input  logic                     PCWrite,
    input  logic                     PCSrc,
    input  logic                     flush,
    input  logic [31:0]              Branch_Address,
    output logic [31:0]              Instruction_out,
    output logic [31:0]              Next_Address_out,
    output logic                     inst_valid,
    output logic [$clog2(DEPTH):0]   fill_level
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [31:0]        r_pc;
    logic [31:0]        r_resp_pc4;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               r_inflight;
    logic               r_drop;
    logic [31:0]        r_inst;
    logic [31:0]        r_next_addr;
    logic               r_valid;
    logic [31:0]        r_fifo_data [DEPTH];
    logic [31:0]        r_fifo_pc4  [DEPTH];

    logic               w_redirect;
    logic [c_cnt_w-1:0] w_occ;
    logic               w_req;
    logic               w_resp;
    logic               w_empty;
    logic               w_pop;
    logic               w_bypass;
    logic               w_push;

    // The in-flight slot counts against capacity so a late response always fits.
    assign w_redirect = PCSrc | flush;
    assign w_occ      = r_count + c_cnt_w'(r_inflight);
    assign w_req      = !reset && !w_redirect && (w_occ < c_cnt_w'(DEPTH));
    assign w_resp     = r_inflight && !r_drop;
    assign w_empty    = (r_count == '0);
    assign w_pop      = !w_redirect && PCWrite && !w_empty;
    assign w_bypass   = !w_redirect && PCWrite && w_empty && w_resp;
    assign w_push     = !w_redirect && w_resp && !w_bypass;

    assign imem_req         = w_req;
    assign imem_addr        = r_pc;
    assign Instruction_out  = r_inst;
    assign Next_Address_out = r_next_addr;
    assign inst_valid       = r_valid;
    assign fill_level       = r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc        <= RESET_PC;
            r_resp_pc4  <= '0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_inflight  <= 1'b0;
            r_drop      <= 1'b0;
            r_inst      <= NOP;
            r_next_addr <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_inflight <= w_req;
            // A response already on its way when redirecting belongs to the old path.
            r_drop     <= w_redirect && r_inflight;

            if (w_redirect) begin
                r_pc <= Branch_Address;
            end else if (w_req) begin
                r_pc       <= r_pc + 32'd4;
                r_resp_pc4 <= r_pc + 32'd4;
            end

            if (w_redirect) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
            end

            if (w_redirect) begin
                r_inst  <= NOP;
                r_valid <= 1'b0;
            end else if (PCWrite) begin
                if (!w_empty) begin
                    r_inst      <= r_fifo_data[r_rd_ptr];
                    r_next_addr <= r_fifo_pc4[r_rd_ptr];
                    r_valid     <= 1'b1;
                end else if (w_resp) begin
                    r_inst      <= imem_rdata;
                    r_next_addr <= r_resp_pc4;
                    r_valid     <= 1'b1;
                end else begin
                    r_inst  <= NOP;
                    r_valid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= imem_rdata;
            r_fifo_pc4[r_wr_ptr]  <= r_resp_pc4;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifq_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifq_prefetch_unit
// Description : Self-checking bench for ifq_prefetch_unit against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifq_prefetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCWrite, PCSrc, flush;
    logic [31:0] Branch_Address;

    logic        imem_req0, imem_req1;
    logic [31:0] imem_addr0, imem_addr1, rdata0, rdata1;
    logic [31:0] inst0, inst1, na0, na1;
    logic        valid0, valid1;
    logic [2:0]  fill0, fill1;

    int total = 0;
    int bad   = 0;
    int k1    = -1;

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] addr);
        return (addr >> 2) + 32'h100;
    endfunction

    // Synchronous memories; junk on idle cycles exposes unwanted captures.
    always @(posedge clk) rdata0 <= imem_req0 ? memf(imem_addr0) : $urandom;
    always @(posedge clk) rdata1 <= imem_req1 ? memf(imem_addr1) : $urandom;

    ifq_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0), .NOP(32'h0)) dut0 (
        .clk(clk), .reset(reset), .imem_req(imem_req0), .imem_addr(imem_addr0),
        .imem_rdata(rdata0), .PCWrite(PCWrite), .PCSrc(PCSrc), .flush(flush),
        .Branch_Address(Branch_Address), .Instruction_out(inst0),
        .Next_Address_out(na0), .inst_valid(valid0), .fill_level(fill0)
    );

    ifq_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8), .NOP(32'h0)) dut1 (
        .clk(clk), .reset(reset), .imem_req(imem_req1), .imem_addr(imem_addr1),
        .imem_rdata(rdata1), .PCWrite(1'b1), .PCSrc(1'b0), .flush(1'b0),
        .Branch_Address(32'h0), .Instruction_out(inst1),
        .Next_Address_out(na1), .inst_valid(valid1), .fill_level(fill1)
    );

    // Reference model: instruction queue plus the single outstanding fetch.
    typedef struct {
        logic [31:0] w;
        logic [31:0] a;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_pc, m_if_addr, m_inst, m_na;
    bit          m_inflight, m_drop, m_valid;

    task automatic m_reset();
        m_q.delete();
        m_pc = 32'h0; m_if_addr = 32'h0;
        m_inflight = 0; m_drop = 0;
        m_inst = 32'h0; m_na = 32'h0; m_valid = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit pcw, input bit src, input bit fl, input logic [31:0] ba);
        bit   red, req, resp;
        ent_t r;
        PCWrite = pcw; PCSrc = src; flush = fl; Branch_Address = ba;
        @(negedge clk);
        red = src | fl;
        req = !red && ((m_q.size() + int'(m_inflight)) < DEPTH);
        chk("imem_req", 32'(imem_req0), 32'(req));
        chk("imem_addr", imem_addr0, m_pc);
        if (k1 >= 0 && k1 <= 2) chk("wrap_addr", imem_addr1, 32'hFFFF_FFF8 + 32'(4 * k1));

        resp = m_inflight && !m_drop;
        r.w  = memf(m_if_addr);
        r.a  = m_if_addr + 32'd4;
        if (red) begin
            m_q.delete();
            m_inst = 32'h0; m_valid = 0;
            m_drop = m_inflight;
            m_inflight = 0;
            m_pc = ba;
        end else begin
            m_drop = 0;
            if (pcw) begin
                if (m_q.size() > 0) begin
                    ent_t h;
                    h = m_q.pop_front();
                    m_inst = h.w; m_na = h.a; m_valid = 1;
                    if (resp) m_q.push_back(r);
                end else if (resp) begin
                    m_inst = r.w; m_na = r.a; m_valid = 1;
                end else begin
                    m_inst = 32'h0; m_valid = 0;
                end
            end else if (resp) begin
                m_q.push_back(r);
            end
            m_inflight = req;
            if (req) begin
                m_if_addr = m_pc;
                m_pc = m_pc + 32'd4;
            end
        end

        @(posedge clk);
        #1;
        chk("inst", inst0, m_inst);
        chk("next_addr", na0, m_na);
        chk("valid", 32'(valid0), 32'(m_valid));
        chk("fill", 32'(fill0), 32'(m_q.size()));
        if (k1 >= 1 && k1 <= 3) begin
            chk("wrap_inst", inst1, memf(32'hFFFF_FFF8 + 32'(4 * (k1 - 1))));
            chk("wrap_na", na1, 32'hFFFF_FFFC + 32'(4 * (k1 - 1)));
            chk("wrap_valid", 32'(valid1), 32'd1);
        end
        if (k1 >= 0 && k1 <= 3) k1++;
    endtask

    initial begin
        reset = 1'b1; PCWrite = 1'b1; PCSrc = 1'b0; flush = 1'b0; Branch_Address = 32'h0;
        m_reset();
        #3;
        chk("rst_inst", inst0, 32'h0);
        chk("rst_na", na0, 32'h0);
        chk("rst_valid", 32'(valid0), 32'd0);
        chk("rst_fill", 32'(fill0), 32'd0);
        chk("rst_req", 32'(imem_req0), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_reset();
        k1 = 0;

        // Streaming from reset
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("first_inst", inst0, 32'h100);
        chk("first_na", na0, 32'h4);
        step(1, 0, 0, 0);
        chk("second_inst", inst0, 32'h101);
        chk("second_na", na0, 32'h8);
        repeat (5) step(1, 0, 0, 0);

        // Stall fills the queue to capacity, then resume
        repeat (8) step(0, 0, 0, 0);
        chk("stall_full", 32'(fill0), 32'd4);
        repeat (6) step(1, 0, 0, 0);

        // Branch redirect with a request in flight
        step(1, 1, 0, 32'h40);
        chk("br_bubble_valid", 32'(valid0), 32'd0);
        chk("br_bubble_inst", inst0, 32'h0);
        for (int i = 0; i < 6 && valid0 !== 1'b1; i++) step(1, 0, 0, 0);
        chk("br_valid", 32'(valid0), 32'd1);
        chk("br_inst", inst0, memf(32'h40));
        chk("br_na", na0, 32'h44);

        // Flush overrides a stall while the queue is full
        for (int i = 0; i < 10 && fill0 != 3'd4; i++) step(0, 0, 0, 0);
        chk("pre_flush_full", 32'(fill0), 32'd4);
        step(0, 0, 1, 32'h200);
        chk("flush_fill", 32'(fill0), 32'd0);
        chk("flush_valid", 32'(valid0), 32'd0);

        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            int r;
            r = int'($urandom_range(0, 19));
            step($urandom_range(0, 3) != 0, r == 0, r == 1, 32'($urandom_range(0, 1023)) << 2);
        end

        // Asynchronous reset mid-stream with three queued words
        repeat (3) step(1, 0, 0, 0);
        for (int i = 0; i < 10 && fill0 != 3'd3; i++) step(0, 0, 0, 0);
        chk("pre_rst_fill", 32'(fill0), 32'd3);
        #2 reset = 1'b1;
        #1;
        chk("arst_inst", inst0, 32'h0);
        chk("arst_na", na0, 32'h0);
        chk("arst_valid", 32'(valid0), 32'd0);
        chk("arst_fill", 32'(fill0), 32'd0);
        chk("arst_req", 32'(imem_req0), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        m_reset();
        repeat (6) step(1, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ifq_prefetch_unit.md
Name: ifq_prefetch_unit

Overview:
- Instruction prefetch queue with PC generation; sits directly upstream of the ID stage and replaces the fetch front end.
- Owns the PC and issues sequential requests to a synchronous instruction memory. Buffers returned words in a small FIFO.
- Drives the IF/ID register outputs (Instruction_out, Next_Address_out) consumed by ID.
- Honours ID stall (PCWrite) and branch redirect/flush (PCSrc, flush, Branch_Address).

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP, 32'h00000000, instruction word driven when no valid instruction is available.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request; the read is performed at this clock edge.
- imem_addr  out  32  fetch address; combinational from the PC register.
- imem_rdata  in  32  instruction word; valid during the cycle after the edge that sampled imem_req=1.
- PCWrite  in  1  1 = ID accepts a new instruction this edge; 0 = hold the IF/ID outputs.
- PCSrc  in  1  branch taken; redirect to Branch_Address.
- flush  in  1  squash; treated identically to PCSrc.
- Branch_Address  in  32  redirect target; sampled when PCSrc or flush is 1.
- Instruction_out  out  32  IF/ID instruction register.
- Next_Address_out  out  32  IF/ID register holding the instruction's PC+4.
- inst_valid  out  1  1 = Instruction_out holds a real fetched word.
- fill_level  out  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, immediate):
  - pc=RESET_PC; FIFO empty with rd/wr pointers 0; inflight=0; drop=0.
  - Instruction_out=NOP; Next_Address_out=0; inst_valid=0; fill_level=0; imem_req=0.
- Request issue:
  - imem_req = !redirect && (fill_level + inflight < DEPTH), where redirect = PCSrc | flush.
  - imem_addr = pc.
  - On an edge with imem_req=1: pc <= pc+4 (wraps 32'hFFFFFFFC -> 0) and inflight <= 1; otherwise inflight <= 0.
  - At most one request is outstanding, so throughput is one word per cycle.
- Response capture: in the cycle after a request, if drop=0, imem_rdata and its PC+4 are the response.
  - Bypass: if the FIFO is empty and PCWrite=1, the response loads directly into Instruction_out/Next_Address_out with inst_valid=1.
  - Otherwise the response is pushed into the FIFO.
- Output (IF/ID) update on each edge with no redirect:
  - PCWrite=0: all three outputs hold. The FIFO may still fill up to DEPTH.
  - PCWrite=1 and FIFO non-empty: pop the head into the outputs, inst_valid=1. A same-cycle response is pushed; occupancy is unchanged.
  - PCWrite=1, FIFO empty, no response: Instruction_out=NOP, inst_valid=0; Next_Address_out holds.
- Redirect (PCSrc=1 or flush=1), which wins over PCWrite and stall:
  - pc <= Branch_Address; FIFO cleared to fill_level=0; imem_req=0 that cycle.
  - drop <= inflight, so any response arriving next cycle is discarded. drop clears after one cycle.
  - Instruction_out <= NOP; inst_valid <= 0.
  - The first request to Branch_Address issues on the next cycle.
- Latency:
  - Redirect edge R, request edge R+1, instruction visible after R+2 (bypass path).
  - From reset release: first request at edge E0, Instruction_out=mem[RESET_PC] after E0+1.
- Boundaries:
  - Full: no request; the FIFO never overflows because the inflight slot is reserved.
  - Empty with PCWrite=1: emits a NOP bubble.
  - Pointers wrap modulo DEPTH.
  - Reset asserted mid-stream discards all queued and in-flight words immediately.

Test Plan:
- Reset, RESET_PC=0, imem[n]=n+0x100, PCWrite=1 -> Instruction_out 0x100, 0x101, 0x102... one per cycle from the 2nd edge after reset. Next_Address_out 4, 8, 12; inst_valid=1 continuously.
- Stream running, PCWrite=0 for 8 cycles -> outputs frozen. Requests stop once fill_level+inflight=4 and fill_level ends at 4. After PCWrite=1, words resume in order with no gap or duplicate.
- PCSrc=1 with Branch_Address=0x40 and one request in flight -> the next output is NOP with inst_valid=0. The in-flight word is dropped and the next cycle shows imem_addr=0x40. The first valid output is imem[0x40] with Next_Address_out=0x44.
- flush=1 and PCWrite=0 in the same cycle with the FIFO full -> fill_level=0 and inst_valid=0 at the next edge; the redirect overrides the stall.
- RESET_PC=32'hFFFFFFF8, run 3 instructions -> fetch addresses FFFFFFF8, FFFFFFFC, 00000000. Next_Address_out FFFFFFFC, 00000000, 00000004.
- Assert reset asynchronously mid-cycle with fill_level=3 -> outputs drop immediately to NOP, 0, 0, with fill_level=0 and imem_req=0, before the next clock edge.
